// File: rtl/round_share_pkg.sv
// Shared helpers for the round_share requantizer and its interface.
package round_share_pkg;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/round_share_if.sv
// Sample-source / consumer bundle for round_share: K input lanes, one rounded output lane.
interface round_share_if
  import round_share_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 8,
  parameter int M = 8
);
  localparam int IW = idx_width(K);

  logic [K*N-1:0] in_data;
  logic [K-1:0]   in_valid;
  logic [K-1:0]   in_ready;
  logic [M-1:0]   out_data;
  logic [IW-1:0]  out_ch;
  logic           out_valid;
  logic [N-1:0]   out_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_ch, out_valid, out_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_ch, out_valid, out_err
  );
endinterface

// File: rtl/round_share_arb.sv
// K-way round-robin arbiter: combinational one-hot grant searched from ptr, pointer
// moves past the winner only when the caller reports that the grant was used.
module round_share_arb
  import round_share_pkg::*;
#(
  parameter int K  = 4,
  parameter int IW = idx_width(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [K-1:0]  req,
  input  logic          advance,
  output logic [K-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < K; off++) begin
      cand = (int'(ptr_q) + off) % K;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
    // Nothing may transfer while reset is asserted.
    if (rst) begin
      grant = '0;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (int'(idx) == K - 1) ? '0 : IW'(int'(idx) + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/round_share.sv
// Shared rounding/requantizing datapath for K channels with optional per-channel
// first-order error feedback; one sample accepted per cycle, outputs registered.
module round_share
  import round_share_pkg::*;
#(
  parameter int K  = 4,
  parameter int N  = 8,
  parameter int M  = 8,
  parameter int P  = 2,
  parameter int NS = 1
) (
  input  logic         clk,
  input  logic         rst,
  round_share_if.slave bus
);
  localparam int IW = idx_width(K);
  localparam int QB = N - P - 1;
  localparam logic [N-1:0] LOW_MASK = N'((1 << QB) - 1);
  localparam logic [N-1:0] HALF_Q   = N'(1 << (QB - 1));
  localparam logic signed [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  logic [K-1:0]  grant;
  logic [IW-1:0] gidx;
  logic          xfer;

  round_share_arb #(.K(K), .IW(IW)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .advance (xfer),
    .grant   (grant),
    .idx     (gidx)
  );

  assign bus.in_ready = grant;
  assign xfer         = |grant;

  logic signed [N-1:0] acc_q [K];
  logic signed [N-1:0] x_sel;
  logic signed [N-1:0] acc_sel;
  logic signed [N:0]   sum_ext;
  logic signed [N-1:0] sum_sat;
  logic [N-1:0]        r_up;
  logic [N-1:0]        r_val;
  logic signed [N-1:0] err_val;

  always_comb begin
    x_sel   = bus.in_data[int'(gidx)*N +: N];
    acc_sel = (NS != 0) ? acc_q[gidx] : '0;
    sum_ext = {x_sel[N-1], x_sel} + {acc_sel[N-1], acc_sel};
    if (sum_ext[N] != sum_ext[N-1]) begin
      sum_sat = sum_ext[N] ? MIN_V : MAX_V;
    end else begin
      sum_sat = sum_ext[N-1:0];
    end
    r_up  = (sum_sat + HALF_Q) & ~LOW_MASK;
    r_val = r_up;
    // Rounding a large positive sum up would wrap to negative; truncate instead.
    if (!sum_sat[N-1] && r_up[N-1]) begin
      r_val = sum_sat & ~LOW_MASK;
    end
    err_val = sum_sat - r_val;
  end

  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_acc
      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q[gi] <= '0;
        end else if ((NS != 0) && grant[gi]) begin
          acc_q[gi] <= err_val;
        end
      end
    end
  endgenerate

  logic [M-1:0]  out_data_q;
  logic [IW-1:0] out_ch_q;
  logic          out_valid_q;
  logic [N-1:0]  out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= '0;
    end else begin
      out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= r_val[N-1 -: M];
        out_ch_q   <= gidx;
        out_err_q  <= err_val;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_round_share.sv
// Bench for round_share: two instances (M=8 with feedback, M=3 plain rounding) driven
// identically and compared every cycle against an arithmetic reference model.
module tb_round_share;
  import round_share_pkg::*;

  localparam int K = 4;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_share_if #(.K(K), .N(N), .M(8)) bus_a ();
  round_share_if #(.K(K), .N(N), .M(3)) bus_b ();

  round_share #(.K(K), .N(N), .M(8), .P(2), .NS(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  round_share #(.K(K), .N(N), .M(3), .P(2), .NS(0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  int passed = 0;
  int total  = 0;

  int ptr;
  int acc [K];
  int m_valid, m_ch, m_data_a, m_err_a, m_data_b, m_err_b;

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Round to a multiple of 32; if that exceeds the 8-bit range, round down instead.
  function automatic int quant(input int s);
    int r;
    r = fdiv(s + 16, 32) * 32;
    if (r > 127) r = fdiv(s, 32) * 32;
    return r;
  endfunction

  function automatic int clamp(input int s);
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic logic [K*N-1:0] pack(input int ch, input int val);
    logic [K*N-1:0] d;
    d = '0;
    d[ch*N +: N] = N'(val);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    ptr = 0;
    for (int i = 0; i < K; i++) acc[i] = 0;
    m_valid = 0; m_ch = 0; m_data_a = 0; m_err_a = 0; m_data_b = 0; m_err_b = 0;
  endtask

  task automatic cycle(input logic r, input logic [K-1:0] v, input logic [K*N-1:0] d);
    int g, c, x, s, q, qb;
    logic [31:0] exp_ready;
    @(negedge clk);
    rst = r;
    bus_a.in_valid = v; bus_a.in_data = d;
    bus_b.in_valid = v; bus_b.in_data = d;
    g = -1;
    if (!r) begin
      for (int off = 0; off < K; off++) begin
        c = (ptr + off) % K;
        if (g < 0 && v[c]) g = c;
      end
    end
    #1;
    exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk("ready_a", 32'(bus_a.in_ready), exp_ready);
    chk("ready_b", 32'(bus_b.in_ready), exp_ready);
    if (r) begin
      model_reset();
    end else if (g >= 0) begin
      x = int'($signed(d[g*N +: N]));
      s = clamp(x + acc[g]);
      q = quant(s);
      m_data_a = q; m_err_a = s - q; acc[g] = s - q;
      qb = quant(x);
      m_data_b = fdiv(qb, 32); m_err_b = x - qb;
      m_ch = g; m_valid = 1;
      ptr = (g + 1) % K;
      $display("tx ch=%0d x=%0d sum=%0d out=%0d err=%0d out3=%0d", g, x, s, q, s - q, m_data_b);
    end else begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("valid_a", 32'(bus_a.out_valid), 32'(m_valid));
    chk("data_a",  32'(bus_a.out_data),  32'(m_data_a & 255));
    chk("ch_a",    32'(bus_a.out_ch),    32'(m_ch));
    chk("err_a",   32'(bus_a.out_err),   32'(m_err_a & 255));
    chk("valid_b", 32'(bus_b.out_valid), 32'(m_valid));
    chk("data_b",  32'(bus_b.out_data),  32'(m_data_b & 7));
    chk("err_b",   32'(bus_b.out_err),   32'(m_err_b & 255));
  endtask

  initial begin
    logic [K*N-1:0] rd;
    rst = 1'b1;
    bus_a.in_valid = '0; bus_a.in_data = '0;
    bus_b.in_valid = '0; bus_b.in_data = '0;
    model_reset();
    cycle(1'b1, 4'b0000, '0);
    cycle(1'b1, 4'b0000, '0);

    // Error diffusion on ch1: 20 -> 32/-12, then 8 -> 0/8
    cycle(1'b0, 4'b0010, pack(1, 20));
    cycle(1'b0, 4'b0010, pack(1, 20));
    cycle(1'b0, 4'b0000, '0);

    // Round-robin fairness with every channel requesting
    for (int i = 0; i < 8; i++) begin
      rd = {$urandom, $urandom};
      cycle(1'b0, 4'b1111, rd);
    end

    // Top overflow on ch0
    cycle(1'b1, 4'b0000, '0);
    cycle(1'b0, 4'b0001, pack(0, 120));
    cycle(1'b0, 4'b0001, pack(0, 127));

    // Negative rounding on ch2
    cycle(1'b1, 4'b0000, '0);
    cycle(1'b0, 4'b0100, pack(2, -17));
    cycle(1'b0, 4'b0100, pack(2, -128));

    // Narrow output without feedback on ch3: 50 twice
    cycle(1'b0, 4'b1000, pack(3, 50));
    cycle(1'b0, 4'b1000, pack(3, 50));

    // Reset mid-stream while ch1 is requesting with a non-zero accumulator
    cycle(1'b0, 4'b0010, pack(1, 20));
    cycle(1'b1, 4'b0010, pack(1, 20));
    cycle(1'b0, 4'b1111, pack(1, 20) | pack(0, 5));
    cycle(1'b1, 4'b0000, '0);
    cycle(1'b0, 4'b0010, pack(1, 20));

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom, $urandom};
      cycle(($urandom_range(0, 39) == 0), 4'($urandom), rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
